addsub_result_buffer: RTL and testbench
=======================================

// Module: addsub_result_buffer
// PURPOSE
//   Registered result stage directly downstream of the 4-bit adder/subtractor.
//   - Captures each sum/cout with a valid/ready handshake and derives the status flags {V,N,Z,C}.
//   - Buffers up to DEPTH results in a FIFO and presents them in order to the consumer.
//   - Keeps a saturating operation counter and a sticky signed-overflow flag.
// PARAMETERS
//   WIDTH   4   data width of sum_in / out_result (matches the adder)
//   DEPTH   2   FIFO entries; power of two, 2..16
//   CNT_W   8   width of op_count
// PORTS
//   clk            in   1        single clock; all state updates on the rising edge
//   rst            in   1        asynchronous, active-high reset
//   in_valid       in   1        upstream result valid
//   in_ready       out  1        buffer can accept this cycle
//   sum_in         in   WIDTH    adder sum
//   cout_in        in   1        adder carry-out
//   mode_in        in   1        0 = add, 1 = subtract (a - b)
//   a_msb          in   1        MSB of operand a, for signed overflow
//   b_msb          in   1        MSB of operand b (un-inverted), for signed overflow
//   out_valid      out  1        head entry valid
//   out_ready      in   1        consumer accepts head
//   out_result     out  WIDTH    head result
//   out_flags      out  4        head flags {V,N,Z,C}
//   op_count       out  CNT_W    number of accepted results, saturating
//   ovf_sticky     out  1        set when any result with V=1 is accepted
//   clr_count      in   1        synchronous clear of op_count and ovf_sticky
// BEHAVIOUR
//   Reset (async, any time, including mid-transfer):
//     - FIFO emptied; out_valid=0, in_ready=1.
//     - out_result=0, out_flags=0, op_count=0, ovf_sticky=0.
//   Handshake and FIFO:
//     - push = in_valid & in_ready; pop = out_valid & out_ready.
//     - in_ready = !full; out_valid = !empty. Both are driven from registered occupancy only.
//     - No combinational path from in_valid to out_valid.
//     - No combinational path from out_ready to in_ready.
//     - Latency: an entry pushed at edge N is visible with out_valid=1 after edge N.
//     - When empty, out_result and out_flags read 0.
//   Boundary conditions:
//     - Simultaneous push and pop with 0 < count < DEPTH: occupancy unchanged; 1 result/cycle.
//     - Full: in_ready=0. A pop at full frees a slot only from the next cycle on.
//     - Empty: pop is impossible (out_valid=0). A push while empty makes out_valid=1 next cycle.
//     - Read and write pointers wrap modulo DEPTH; order is strictly FIFO.
//   Flags, computed from the inputs at push time and stored with the entry:
//     - C = mode_in ? ~cout_in : cout_in (borrow on subtract, carry on add).
//     - Z = (sum_in == 0).
//     - N = sum_in[WIDTH-1].
//     - Let s = sum_in[WIDTH-1]. Add: V = (a_msb == b_msb) & (s != a_msb).
//     - Subtract: V = (a_msb != b_msb) & (s != a_msb).
//   Counters:
//     - op_count increments on every push and holds at 2^CNT_W-1.
//     - ovf_sticky is set on a push with V=1.
//     - clr_count has priority: if clr_count and push coincide, the next value is op_count=0, ovf_sticky=0.
//     - clr_count does not affect FIFO contents.
// TESTING
//   1 add 7+1: sum_in=8, cout_in=0, mode_in=0, a_msb=0, b_msb=0 -> next cycle out_valid=1, out_result=8, out_flags=4'b1100.
//   2 sub 5-5: sum_in=0, cout_in=1, mode_in=1, a_msb=0, b_msb=0 -> out_result=0, out_flags=4'b0010; ovf_sticky unchanged.
//   3 backpressure: out_ready=0, present 3 results (1,2,3) -> 2 accepted, in_ready=0; out_ready=1 -> 1,2,3 in order, none lost.
//   4 streaming: in_valid=1 and out_ready=1 for 10 values 0..9 -> occupancy stays 1, one output per cycle, op_count=10.
//   5 saturation (CNT_W=2): 5 pushes -> op_count=3; clr_count together with a push -> op_count=0, ovf_sticky=0.
//   6 reset mid-op: FIFO full, ovf_sticky=1, assert rst between edges -> immediately out_valid=0, in_ready=1, all outputs 0.

Source files
------------

// File: rtl/addsub_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : addsub_result_buffer
// Purpose  : Registered result stage for the 4-bit adder/subtractor. Each
//            accepted result is stored together with its {V,N,Z,C} flags in
//            a small FIFO and presented in order to the consumer. A
//            saturating operation counter and a sticky signed-overflow flag
//            are maintained alongside.
// Ports    : clk, rst (async, active-high)
//            in_valid/in_ready, sum_in, cout_in, mode_in, a_msb, b_msb
//            out_valid/out_ready, out_result, out_flags
//            op_count, ovf_sticky, clr_count
// Revision : 1.0 - initial release
// ============================================================================
module addsub_result_buffer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             cout_in,
  input  logic             mode_in,
  input  logic             a_msb,
  input  logic             b_msb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic [CNT_W-1:0] op_count,
  output logic             ovf_sticky,
  input  logic             clr_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] c_DEPTH_CNT = (AW+1)'(DEPTH);

  // Storage: one word per entry holding {flags, result}.
  logic [WIDTH+3:0] mem_q [DEPTH];

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic             ovf_sticky_q, ovf_sticky_d;

  logic             w_push;
  logic             w_pop;
  logic             w_flag_v;
  logic             w_flag_n;
  logic             w_flag_z;
  logic             w_flag_c;
  logic [WIDTH+3:0] w_wr_word;

  // Handshake is derived purely from registered occupancy, so there is no
  // combinational path from in_valid or out_ready to either ready/valid.
  assign in_ready  = (count_q != c_DEPTH_CNT);
  assign out_valid = (count_q != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // Status flags for the incoming result.
  // On subtract the adder sees ~b, so signed overflow needs differing MSBs.
  assign w_flag_c = mode_in ? ~cout_in : cout_in;
  assign w_flag_z = (sum_in == '0);
  assign w_flag_n = sum_in[WIDTH-1];
  assign w_flag_v = (mode_in ? (a_msb != b_msb) : (a_msb == b_msb))
                    & (sum_in[WIDTH-1] != a_msb);
  assign w_wr_word = {w_flag_v, w_flag_n, w_flag_z, w_flag_c, sum_in};

  // Head entry is masked to zero while empty so stale storage never leaks.
  assign out_result = out_valid ? mem_q[rptr_q][WIDTH-1:0]     : '0;
  assign out_flags  = out_valid ? mem_q[rptr_q][WIDTH+3:WIDTH] : '0;
  assign op_count   = op_count_q;
  assign ovf_sticky = ovf_sticky_q;

  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    op_count_d   = op_count_q;
    ovf_sticky_d = ovf_sticky_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    if (w_push) wptr_d = wptr_q + 1'b1;
    if (w_pop)  rptr_d = rptr_q + 1'b1;

    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Clear wins over a coincident push.
    if (clr_count) begin
      op_count_d   = '0;
      ovf_sticky_d = 1'b0;
    end else if (w_push) begin
      if (op_count_q != '1) op_count_d = op_count_q + 1'b1;
      if (w_flag_v)         ovf_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      op_count_q   <= '0;
      ovf_sticky_q <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      op_count_q   <= op_count_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  // Data array needs no reset: reads are masked by out_valid.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wptr_q] <= w_wr_word;
  end

endmodule
`default_nettype wire

// File: tb/tb_addsub_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_result_buffer
// Purpose  : Self-checking bench for addsub_result_buffer. A queue-based
//            reference model predicts every output each cycle; directed
//            scenarios are followed by a randomized phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_addsub_result_buffer;

  localparam int WIDTH = 4;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum_in;
  logic             cout_in;
  logic             mode_in;
  logic             a_msb;
  logic             b_msb;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_flags;
  logic [CNT_W-1:0] op_count;
  logic             ovf_sticky;
  logic             clr_count;

  addsub_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .sum_in(sum_in), .cout_in(cout_in), .mode_in(mode_in),
    .a_msb(a_msb), .b_msb(b_msb),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .op_count(op_count), .ovf_sticky(ovf_sticky), .clr_count(clr_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model
  typedef struct { logic [3:0] r; logic [3:0] f; } ent_t;
  ent_t m_q[$];
  int   m_cnt;
  bit   m_sticky;

  function automatic logic [3:0] ref_flags(logic [3:0] s, bit co, bit md,
                                           bit am, bit bm);
    bit v, n, z, c, beff;
    c    = md ? !co : co;
    z    = (s == 4'd0);
    n    = (s >= 4'd8);
    beff = md ? !bm : bm;                 // operand actually fed to adder
    v    = (am == beff) && (n != am);
    return {v, n, z, c};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("in_ready",   32'(in_ready),   32'(m_q.size() < DEPTH));
    check("out_valid",  32'(out_valid),  32'(m_q.size() > 0));
    check("out_result", 32'(out_result), (m_q.size() > 0) ? 32'(m_q[0].r) : 32'd0);
    check("out_flags",  32'(out_flags),  (m_q.size() > 0) ? 32'(m_q[0].f) : 32'd0);
    check("op_count",   32'(op_count),   32'((m_cnt > CMAX) ? CMAX : m_cnt));
    check("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cnt    = 0;
    m_sticky = 0;
  endtask

  // One clock cycle: drive, check current outputs, advance model and DUT.
  task automatic cycle(input bit iv, input logic [3:0] s, input bit co,
                       input bit md, input bit am, input bit bm,
                       input bit ordy, input bit clr, output bit pushed);
    ent_t e;
    bit   pop;
    in_valid  = iv;  sum_in = s;   cout_in = co; mode_in = md;
    a_msb     = am;  b_msb  = bm;  out_ready = ordy; clr_count = clr;
    check_outputs();
    pushed = iv && (m_q.size() < DEPTH);
    pop    = ordy && (m_q.size() > 0);
    e.r = s;
    e.f = ref_flags(s, co, md, am, bm);
    if (pop)    void'(m_q.pop_front());
    if (pushed) m_q.push_back(e);
    if (clr) begin
      m_cnt = 0; m_sticky = 0;
    end else if (pushed) begin
      m_cnt++;
      if (e.f[3]) m_sticky = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit ordy);
    bit p;
    cycle(0, 4'd0, 0, 0, 0, 0, ordy, 0, p);
  endtask

  initial begin
    bit p;
    int guard;
    model_reset();
    rst = 1'b1; in_valid = 0; sum_in = 0; cout_in = 0; mode_in = 0;
    a_msb = 0; b_msb = 0; out_ready = 0; clr_count = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();                      // reset state
    rst = 1'b0;

    // 1: add 7+1 -> 8, flags V,N
    cycle(1, 4'd8, 0, 0, 0, 0, 0, 0, p);
    check("t1_result", 32'(out_result), 32'd8);
    check("t1_flags",  32'(out_flags),  32'b1100);
    idle(1);

    // 2: sub 5-5 -> 0, flags Z; sticky already set by test 1, stays set
    cycle(1, 4'd0, 1, 1, 0, 0, 0, 0, p);
    check("t2_flags", 32'(out_flags), 32'b0010);
    idle(1);
    idle(0);

    // 3: backpressure with 1,2,3 then drain in order
    for (int v = 1; v <= 3; v++) begin
      p = 0; guard = 0;
      while (!p && guard < 20) begin
        cycle(1, 4'(v), 0, 0, 0, 0, (guard >= 3), 0, p);
        guard++;
      end
      check("t3_accepted", 32'(p), 32'd1);
    end
    for (int v = 0; v < 4; v++) idle(1);

    // 4: streaming 0..9, occupancy stays at one entry
    cycle(0, 4'd0, 0, 0, 0, 0, 0, 1, p);  // clear counters
    for (int v = 0; v < 10; v++) begin
      cycle(1, 4'(v), 0, 0, 0, 0, 1, 0, p);
      check("t4_stream_valid", 32'(out_valid), 32'd1);
    end
    check("t4_op_count", 32'(op_count), 32'd10);
    idle(1);

    // 5: saturation, then clear coinciding with an overflowing push
    for (int v = 0; v < CMAX + 5; v++) cycle(1, 4'd8, 0, 0, 0, 0, 1, 0, p);
    check("t5_sat", 32'(op_count), 32'(CMAX));
    cycle(1, 4'd8, 0, 0, 0, 0, 1, 1, p);
    check("t5_clr_cnt", 32'(op_count), 32'd0);
    check("t5_clr_ovf", 32'(ovf_sticky), 32'd0);

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 4'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0, p);
    end

    // 6: reset mid-operation with full FIFO and sticky overflow
    idle(1); idle(1);
    cycle(1, 4'd8, 0, 0, 0, 0, 0, 0, p);
    cycle(1, 4'd9, 0, 0, 0, 0, 0, 0, p);
    check("t6_full", 32'(in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1);
    cycle(1, 4'd3, 0, 0, 0, 0, 0, 0, p);
    check("t6_after", 32'(out_result), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
